// File: rtl/series_result_axis_packer_pkg.sv
// Shared definitions for the series-result AXI4-Stream packer and the later stream stages.
package series_result_axis_packer_pkg;

   localparam int unsigned DATA_W_DEF = 32;

   // Sideband bit offsets above the data field of a FIFO entry {tuser, tlast, data}
   localparam int unsigned TLAST_BIT = 0;
   localparam int unsigned TUSER_BIT = 1;

   typedef enum logic {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } frame_state_e;

endpackage

// File: rtl/series_result_axis_packer_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is held in an output register.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH      = 34,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int unsigned DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [WIDTH-1:0]    head_q, head_d;
   logic                valid_q, valid_d;
   logic                do_wr, do_rd;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign empty   = ~valid_q;
   assign rd_data = head_q;
   assign do_rd   = rd_en & valid_q;
   // A pop frees a slot in the same cycle, so a write into a full FIFO is still taken
   assign do_wr   = wr_en & (~full | do_rd);

   // Next pointers and next head; the head bypasses memory when the write lands on the new read slot
   always_comb begin
      wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      valid_d  = (wr_ptr_d != rd_ptr_d);
      head_d   = mem[rd_ptr_d[DEPTH_LOG2-1:0]];
      if (do_wr && (rd_ptr_d == wr_ptr_q)) begin
         head_d = wr_data;
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
      end
   end

   // Pointer, head register and valid state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: rtl/series_result_axis_packer.sv
// Packs free-running series-adder result strobes into a framed AXI4-Stream toward the DMA.
module series_result_axis_packer
   import series_result_axis_packer_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] res_data_i,
   input  logic              res_vld_i,
   input  logic              res_first_i,
   input  logic              res_last_i,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic              overflow_o,
   output logic [CNT_W-1:0]  frame_words_o,
   output logic              frame_done_o
);

   localparam int unsigned ENTRY_W = DATA_W + 2;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic               push, in_tuser, pop;
   logic               fifo_wr, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] entry, head;
   logic [DEPTH_LOG2:0] fifo_level_unused;

   frame_state_e       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, words_q, words_d;
   logic               done_q, done_d, overflow_q;

   assign push     = res_vld_i | res_last_i;
   assign in_tuser = res_vld_i & res_first_i;
   assign pop      = m_axis_tvalid & m_axis_tready;
   assign fifo_wr  = push & (~fifo_full | pop);

   // Entry assembly {tuser, tlast, data}
   always_comb begin
      entry                       = '0;
      entry[DATA_W-1:0]           = res_data_i;
      entry[DATA_W + TLAST_BIT]   = res_last_i;
      entry[DATA_W + TUSER_BIT]   = in_tuser;
   end

   sync_fifo_fwft #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (entry),
      .rd_en   (m_axis_tready),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level_unused)
   );

   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tdata  = head[DATA_W-1:0];
   assign m_axis_tlast  = head[DATA_W + TLAST_BIT];
   assign m_axis_tuser  = head[DATA_W + TUSER_BIT];
   assign overflow_o    = overflow_q;
   assign frame_words_o = words_q;
   assign frame_done_o  = done_q;

   // Frame tracking counts every push, including words dropped on overflow
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      words_d = words_q;
      done_d  = 1'b0;
      if (push) begin
         if (in_tuser || (state_q == IDLE)) begin
            cnt_d = CNT_ONE;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
         end
         if (res_last_i) begin
            state_d = IDLE;
            words_d = cnt_d;
            done_d  = 1'b1;
         end else begin
            state_d = IN_FRAME;
         end
      end
   end

   // Frame state, counters and sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         words_q    <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         words_q    <= words_d;
         done_q     <= done_d;
         overflow_q <= overflow_q | (push & fifo_full & ~pop);
      end
   end

endmodule

// File: tb/tb_series_result_axis_packer.sv
// Directed, table-driven bench for series_result_axis_packer.
module tb_series_result_axis_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] res_data_i;
   logic        res_vld_i, res_first_i, res_last_i;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
   logic        overflow_o;
   logic [15:0] frame_words_o;
   logic        frame_done_o;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned beats    = 0;

   logic [33:0] exp_q [$];
   logic        stall_pending = 1'b0;
   logic [33:0] stall_beat    = '0;

   typedef struct {
      logic        vld, first, last;
      logic [31:0] data;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_last, e_user, e_done;
      logic [15:0] e_words;
   } vec_t;
   vec_t tbl [15];

   series_result_axis_packer #(
      .DATA_W     (32),
      .DEPTH_LOG2 (4),
      .CNT_W      (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .res_data_i    (res_data_i),
      .res_vld_i     (res_vld_i),
      .res_first_i   (res_first_i),
      .res_last_i    (res_last_i),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .overflow_o    (overflow_o),
      .frame_words_o (frame_words_o),
      .frame_done_o  (frame_done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, score a handshake if one happens at the next edge, check stall stability
   task automatic cycle(input logic vld, input logic first, input logic last,
                        input logic [31:0] data, input logic rdy);
      logic [33:0] cur;
      logic [33:0] want;
      res_vld_i     = vld;
      res_first_i   = first;
      res_last_i    = last;
      res_data_i    = data;
      m_axis_tready = rdy;
      cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (stall_pending) begin
         chk("stall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
         chk("stall_beat", {30'd0, cur}, {30'd0, stall_beat});
      end
      if (m_axis_tvalid && rdy) begin
         beats++;
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {30'd0, cur}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            want = exp_q.pop_front();
            chk("beat", {30'd0, cur}, {30'd0, want});
         end
      end
      stall_pending = m_axis_tvalid && !rdy;
      stall_beat    = cur;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int unsigned bound);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      chk("drain_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      res_vld_i = 1'b0; res_first_i = 1'b0; res_last_i = 1'b0;
      res_data_i = '0;  m_axis_tready = 1'b0;
      exp_q.delete();
      stall_pending = 1'b0;
      beats = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h11111111, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h22222222, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b1, 16'd3};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'hAAAA0001, 1'b1, 32'hAAAA0001, 1'b0, 1'b1, 1'b0, 16'd3};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'hAAAA0002, 1'b1, 32'hAAAA0002, 1'b0, 1'b0, 1'b0, 16'd3};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h000000BB, 1'b1, 32'h000000BB, 1'b1, 1'b0, 1'b1, 16'd3};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd3};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h00000005, 1'b1, 32'h00000005, 1'b1, 1'b0, 1'b1, 16'd1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h00000061, 1'b1, 32'h00000061, 1'b0, 1'b1, 1'b0, 16'd1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h00000062, 1'b1, 32'h00000062, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h00000063, 1'b1, 32'h00000063, 1'b0, 1'b1, 1'b0, 16'd1};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h00000064, 1'b1, 32'h00000064, 1'b1, 1'b0, 1'b1, 16'd2};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'd2};

      rst_n = 1'b0;
      res_vld_i = 1'b0; res_first_i = 1'b0; res_last_i = 1'b0;
      res_data_i = '0;  m_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      chk("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
      chk("rst_tlast_tuser", {62'd0, m_axis_tlast, m_axis_tuser}, 64'd0);
      chk("rst_overflow", {63'd0, overflow_o}, 64'd0);
      chk("rst_words", {48'd0, frame_words_o}, 64'd0);
      chk("rst_done", {63'd0, frame_done_o}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: short frames, last-only flush, stray word, restart inside a frame
      for (int i = 0; i < 15; i++) begin
         res_vld_i = tbl[i].vld;   res_first_i = tbl[i].first;
         res_last_i = tbl[i].last; res_data_i = tbl[i].data;
         m_axis_tready = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_tvalid", i), {63'd0, m_axis_tvalid}, {63'd0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_done", i), {63'd0, frame_done_o}, {63'd0, tbl[i].e_done});
         chk($sformatf("tbl%0d_words", i), {48'd0, frame_words_o}, {48'd0, tbl[i].e_words});
         if (tbl[i].e_valid) begin
            chk($sformatf("tbl%0d_tdata", i), {32'd0, m_axis_tdata}, {32'd0, tbl[i].e_data});
            chk($sformatf("tbl%0d_tlast", i), {63'd0, m_axis_tlast}, {63'd0, tbl[i].e_last});
            chk($sformatf("tbl%0d_tuser", i), {63'd0, m_axis_tuser}, {63'd0, tbl[i].e_user});
         end
      end

      // Stall with 20 pushes: 16 kept, 4 dropped, frame still closes with 20
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i < 16) exp_q.push_back({(i == 0), 1'b0, 32'h100 + 32'(i)});
         cycle(1'b1, (i == 0), (i == 19), 32'h100 + 32'(i), 1'b0);
         chk($sformatf("stall_ovf%0d", i), {63'd0, overflow_o}, {63'd0, (i >= 16)});
      end
      chk("stall_words", {48'd0, frame_words_o}, 64'd20);
      chk("stall_done", {63'd0, frame_done_o}, 64'd1);
      drain(40);
      chk("stall_beats", 64'(beats), 64'd16);
      chk("stall_ovf_sticky", {63'd0, overflow_o}, 64'd1);

      // Continuous 8-word frame with tready toggling 1010...
      do_reset();
      for (int c = 0; c < 30; c++) begin
         if (c < 8) begin
            exp_q.push_back({(c == 0), (c == 7), 32'h200 + 32'(c)});
            cycle(1'b1, (c == 0), (c == 7), 32'h200 + 32'(c), (c % 2 == 0));
         end else begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, (c % 2 == 0));
         end
      end
      chk("toggle_left", 64'(exp_q.size()), 64'd0);
      chk("toggle_beats", 64'(beats), 64'd8);
      chk("toggle_words", {48'd0, frame_words_o}, 64'd8);
      chk("toggle_ovf", {63'd0, overflow_o}, 64'd0);

      // Full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({(i == 0), 1'b0, 32'h300 + 32'(i)});
         cycle(1'b1, (i == 0), 1'b0, 32'h300 + 32'(i), 1'b0);
      end
      chk("full_level", 64'(dut.u_fifo.level), 64'd16);
      chk("full_ovf", {63'd0, overflow_o}, 64'd0);
      for (int i = 16; i < 20; i++) begin
         exp_q.push_back({1'b0, (i == 19), 32'h300 + 32'(i)});
         cycle(1'b1, 1'b0, (i == 19), 32'h300 + 32'(i), 1'b1);
         chk($sformatf("pushpop_level%0d", i), 64'(dut.u_fifo.level), 64'd16);
         chk($sformatf("pushpop_ovf%0d", i), {63'd0, overflow_o}, 64'd0);
      end
      drain(40);
      chk("pushpop_beats", 64'(beats), 64'd20);

      // Reset mid-frame drops tvalid at once; a fresh 1-word frame follows
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, 32'h401, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 32'h402, 1'b0);
      chk("mid_tvalid_pre", {63'd0, m_axis_tvalid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_tvalid_async", {63'd0, m_axis_tvalid}, 64'd0);
      chk("mid_words_async", {48'd0, frame_words_o}, 64'd0);
      exp_q.delete();
      stall_pending = 1'b0;
      beats = 0;
      res_vld_i = 1'b0; res_first_i = 1'b0; res_last_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      exp_q.push_back({1'b1, 1'b1, 32'h4FF});
      cycle(1'b1, 1'b1, 1'b1, 32'h4FF, 1'b0);
      chk("one_word_words", {48'd0, frame_words_o}, 64'd1);
      chk("one_word_done", {63'd0, frame_done_o}, 64'd1);
      drain(10);
      chk("one_word_done_clear", {63'd0, frame_done_o}, 64'd0);
      chk("one_word_beats", 64'(beats), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
